// File: rtl/intdiv_sched.sv
// Issue scheduler and in-order result router sharing one fixed-latency signed divider
// between two requesters, with credit-based flow control and divide-by-zero interception.
module intdiv_sched #(
    parameter int N       = 4,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         a_req_valid,
    output logic         a_req_ready,
    input  logic [N-1:0] a_req_x,
    input  logic [N-1:0] a_req_y,
    input  logic         b_req_valid,
    output logic         b_req_ready,
    input  logic [N-1:0] b_req_x,
    input  logic [N-1:0] b_req_y,
    output logic         a_rsp_valid,
    input  logic         a_rsp_ready,
    output logic [N-1:0] a_rsp_z,
    output logic [N-1:0] a_rsp_r,
    output logic         a_rsp_div0,
    output logic         b_rsp_valid,
    input  logic         b_rsp_ready,
    output logic [N-1:0] b_rsp_z,
    output logic [N-1:0] b_rsp_r,
    output logic         b_rsp_div0,
    output logic [N-1:0] div_x,
    output logic [N-1:0] div_y,
    input  logic [N-1:0] div_z,
    input  logic [N-1:0] div_r,
    output logic         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [AW-1:0] P_ONE   = AW'(1);
    localparam logic [AW-1:0] P_LAST  = AW'(DEPTH - 1);
    localparam logic [N-1:0]  ONE_N   = N'(1);

    typedef struct packed {
        logic         vld;
        logic         own;
        logic         d0;
        logic [N-1:0] x;
    } tag_t;

    logic         req_valid [2];
    logic [N-1:0] req_x     [2];
    logic [N-1:0] req_y     [2];
    logic         rsp_ready [2];
    logic         rsp_valid [2];
    logic [N-1:0] rsp_z     [2];
    logic [N-1:0] rsp_r     [2];
    logic         rsp_d0    [2];
    logic         elig      [2];

    logic [1:0]   grant;
    logic         prio_q, prio_d;
    logic         issue, issue_d0;
    logic [N-1:0] issue_x, issue_y;
    tag_t         tag_q [LATENCY];
    tag_t         tag_d [LATENCY];
    tag_t         last_tag;
    logic [N-1:0] ret_z, ret_r;

    assign req_valid[0] = a_req_valid;
    assign req_valid[1] = b_req_valid;
    assign req_x[0]     = a_req_x;
    assign req_x[1]     = b_req_x;
    assign req_y[0]     = a_req_y;
    assign req_y[1]     = b_req_y;
    assign rsp_ready[0] = a_rsp_ready;
    assign rsp_ready[1] = b_rsp_ready;

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign a_rsp_valid = rsp_valid[0];
    assign a_rsp_z     = rsp_z[0];
    assign a_rsp_r     = rsp_r[0];
    assign a_rsp_div0  = rsp_d0[0];
    assign b_rsp_valid = rsp_valid[1];
    assign b_rsp_z     = rsp_z[1];
    assign b_rsp_r     = rsp_r[1];
    assign b_rsp_div0  = rsp_d0[1];

    // prio_q = 0 means A wins a tie; it flips only when someone is actually granted.
    always_comb begin
        grant[0] = elig[0] && (!elig[1] || !prio_q);
        grant[1] = elig[1] && (!elig[0] || prio_q);
        issue    = grant[0] || grant[1];
        issue_x  = grant[1] ? req_x[1] : req_x[0];
        issue_y  = grant[1] ? req_y[1] : req_y[0];
        issue_d0 = issue && (issue_y == '0);
        div_x    = issue ? issue_x : '0;
        div_y    = (!issue || issue_d0) ? ONE_N : issue_y;
        prio_d   = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : prio_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Tag pipeline mirrors the divider so each result knows its owner and div0 status.
    assign tag_d[0] = {issue, grant[1], issue_d0, issue_x};
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign last_tag = tag_q[LATENCY-1];
    assign ret_z    = last_tag.d0 ? '1 : div_z;
    assign ret_r    = last_tag.d0 ? last_tag.x : div_r;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [CW-1:0] cred_q, cred_d, cnt_q, cnt_d;
            logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
            logic          push, pop;
            logic [N-1:0]  mem_z  [DEPTH];
            logic [N-1:0]  mem_r  [DEPTH];
            logic          mem_d0 [DEPTH];

            assign push         = last_tag.vld && (last_tag.own == 1'(gi));
            assign rsp_valid[gi] = (cnt_q != '0);
            assign pop          = rsp_valid[gi] && rsp_ready[gi];
            assign elig[gi]     = req_valid[gi] && (cred_q < C_DEPTH);
            assign rsp_z[gi]    = rsp_valid[gi] ? mem_z[rd_q] : '0;
            assign rsp_r[gi]    = rsp_valid[gi] ? mem_r[rd_q] : '0;
            assign rsp_d0[gi]   = rsp_valid[gi] ? mem_d0[rd_q] : 1'b0;

            always_comb begin
                cred_d = cred_q;
                if (grant[gi] && !pop) begin
                    cred_d = cred_q + C_ONE;
                end else if (!grant[gi] && pop) begin
                    cred_d = cred_q - C_ONE;
                end
                cnt_d = cnt_q;
                if (push && !pop) begin
                    cnt_d = cnt_q + C_ONE;
                end else if (!push && pop) begin
                    cnt_d = cnt_q - C_ONE;
                end
                wr_d = wr_q;
                if (push) begin
                    wr_d = (wr_q == P_LAST) ? '0 : wr_q + P_ONE;
                end
                rd_d = rd_q;
                if (pop) begin
                    rd_d = (rd_q == P_LAST) ? '0 : rd_q + P_ONE;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cred_q <= '0;
                    cnt_q  <= '0;
                    wr_q   <= '0;
                    rd_q   <= '0;
                end else begin
                    cred_q <= cred_d;
                    cnt_q  <= cnt_d;
                    wr_q   <= wr_d;
                    rd_q   <= rd_d;
                end
            end

            always_ff @(posedge clock) begin
                if (push) begin
                    mem_z[wr_q]  <= ret_z;
                    mem_r[wr_q]  <= ret_r;
                    mem_d0[wr_q] <= last_tag.d0;
                end
            end

            // Credits make a retire into a full, non-popping FIFO impossible.
            a_no_overflow: assert property (@(posedge clock) disable iff (reset)
                !(push && !pop && (cnt_q == C_DEPTH)));
        end
    endgenerate

    always_comb begin
        busy = rsp_valid[0] || rsp_valid[1];
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy || tag_q[i].vld;
        end
    end

endmodule

// File: tb/tb_intdiv_sched.sv
// Scoreboard bench for intdiv_sched with a behavioural fixed-latency divider model;
// directed vectors carry hand-computed quotient/remainder expectations.
module tb_intdiv_sched;

    localparam int N     = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         a_req_valid, b_req_valid, a_req_ready, b_req_ready;
    logic [N-1:0] a_req_x, a_req_y, b_req_x, b_req_y;
    logic         a_rsp_valid, b_rsp_valid, a_rsp_ready, b_rsp_ready;
    logic [N-1:0] a_rsp_z, a_rsp_r, b_rsp_z, b_rsp_r;
    logic         a_rsp_div0, b_rsp_div0;
    logic [N-1:0] div_x, div_y, div_z, div_r;
    logic         busy;

    intdiv_sched #(.N(N), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_x(a_req_x), .a_req_y(a_req_y),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_x(b_req_x), .b_req_y(b_req_y),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_z(a_rsp_z), .a_rsp_r(a_rsp_r),
        .a_rsp_div0(a_rsp_div0),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_z(b_rsp_z), .b_rsp_r(b_rsp_r),
        .b_rsp_div0(b_rsp_div0),
        .div_x(div_x), .div_y(div_y), .div_z(div_z), .div_r(div_r), .busy(busy)
    );

    always #5 clock = ~clock;

    // Divider model: operands sampled at an edge appear on div_z/div_r LAT-1 edges later.
    logic [N-1:0] dz_pipe [LAT];
    logic [N-1:0] dr_pipe [LAT];
    always @(posedge clock) begin
        if (div_y == '0) begin
            dz_pipe[0] <= '0;
            dr_pipe[0] <= '0;
        end else begin
            dz_pipe[0] <= N'($signed(div_x) / $signed(div_y));
            dr_pipe[0] <= N'($signed(div_x) % $signed(div_y));
        end
        for (int i = 1; i < LAT; i++) begin
            dz_pipe[i] <= dz_pipe[i-1];
            dr_pipe[i] <= dr_pipe[i-1];
        end
    end
    assign div_z = dz_pipe[LAT-1];
    assign div_r = dr_pipe[LAT-1];

    typedef struct packed {
        logic [N-1:0] z;
        logic [N-1:0] r;
        logic         d0;
    } rsp_t;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
        logic [N-1:0] r;
        logic         d0;
    } vec_t;

    rsp_t exp_a[$];
    rsp_t exp_b[$];
    rsp_t a_cur, b_cur, ea, eb;
    int   glog[$];
    int   tests = 0, fails = 0;
    int   a_iss = 0, b_iss = 0, a_rcv = 0, b_rcv = 0;
    logic [N-1:0] cap_x_b, cap_y_b;
    vec_t va [4];
    vec_t vb [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: records handshakes into the scoreboard and checks every popped response.
    always @(negedge clock) begin
        if (reset) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (a_req_valid && a_req_ready) begin
                exp_a.push_back(a_cur);
                a_iss++;
                glog.push_back(0);
                $display("[TB] issue A x=%h y=%h div_y=%h", a_req_x, a_req_y, div_y);
            end
            if (b_req_valid && b_req_ready) begin
                exp_b.push_back(b_cur);
                b_iss++;
                glog.push_back(1);
                $display("[TB] issue B x=%h y=%h div_y=%h", b_req_x, b_req_y, div_y);
            end
            if (a_rsp_valid && a_rsp_ready) begin
                a_rcv++;
                $display("[TB] resp A z=%h r=%h div0=%b", a_rsp_z, a_rsp_r, a_rsp_div0);
                if (exp_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL a_unexpected: got z=%h r=%h div0=%b, required no response",
                             a_rsp_z, a_rsp_r, a_rsp_div0);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_rsp {z,r,div0}", {a_rsp_z, a_rsp_r, a_rsp_div0}, ea);
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                b_rcv++;
                $display("[TB] resp B z=%h r=%h div0=%b", b_rsp_z, b_rsp_r, b_rsp_div0);
                if (exp_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL b_unexpected: got z=%h r=%h div0=%b, required no response",
                             b_rsp_z, b_rsp_r, b_rsp_div0);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_rsp {z,r,div0}", {b_rsp_z, b_rsp_r, b_rsp_div0}, eb);
                end
            end
        end
    end

    task automatic issue_a(input vec_t v);
        a_cur       = {v.z, v.r, v.d0};
        a_req_x     = v.x;
        a_req_y     = v.y;
        a_req_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clock);
            if (a_req_ready) break;
            if (i >= 60) begin
                tests++;
                fails++;
                $display("[TB] FAIL a_issue_timeout: got no a_req_ready, required grant within 60 cycles");
                break;
            end
        end
        @(posedge clock);
        #1;
        a_req_valid = 1'b0;
    endtask

    task automatic issue_b(input vec_t v);
        b_cur       = {v.z, v.r, v.d0};
        b_req_x     = v.x;
        b_req_y     = v.y;
        b_req_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clock);
            if (b_req_ready) begin
                cap_x_b = div_x;
                cap_y_b = div_y;
                break;
            end
            if (i >= 60) begin
                tests++;
                fails++;
                $display("[TB] FAIL b_issue_timeout: got no b_req_ready, required grant within 60 cycles");
                break;
            end
        end
        @(posedge clock);
        #1;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; ; i++) begin
            @(negedge clock);
            if (!busy && exp_a.size() == 0 && exp_b.size() == 0) break;
            if (i >= 300) begin
                tests++;
                fails++;
                $display("[TB] FAIL idle_timeout: got busy=%b pending=%0d/%0d, required idle",
                         busy, exp_a.size(), exp_b.size());
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_a, base_b, base_ai, base_bi, n;
        logic bseen, vseen;

        // Hand-computed 4-bit signed vectors {x, y, z, r, div0}.
        va[0] = {4'h7, 4'h2, 4'h3, 4'h1, 1'b0};   //  7 /  2 =  3 r  1
        va[1] = {4'h8, 4'h3, 4'hE, 4'hE, 1'b0};   // -8 /  3 = -2 r -2
        va[2] = {4'h5, 4'hE, 4'hE, 4'h1, 1'b0};   //  5 / -2 = -2 r  1
        va[3] = {4'h0, 4'h5, 4'h0, 4'h0, 1'b0};   //  0 /  5 =  0 r  0
        vb[0] = {4'hA, 4'h4, 4'hF, 4'hE, 1'b0};   // -6 /  4 = -1 r -2
        vb[1] = {4'h7, 4'h7, 4'h1, 4'h0, 1'b0};   //  7 /  7 =  1 r  0
        vb[2] = {4'hB, 4'hD, 4'h1, 4'hE, 1'b0};   // -5 / -3 =  1 r -2
        vb[3] = {4'h3, 4'h0, 4'hF, 4'h3, 1'b1};   //  3 /  0 -> div0

        reset = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_req_x = '0; a_req_y = '0; b_req_x = '0; b_req_y = '0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_cur = '0; b_cur = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset a_req_ready", a_req_ready, 0);
        check("reset b_req_ready", b_req_ready, 0);
        check("reset a_rsp_valid", a_rsp_valid, 0);
        check("reset b_rsp_valid", b_rsp_valid, 0);
        check("reset a_rsp", {a_rsp_z, a_rsp_r, a_rsp_div0}, 0);
        check("reset b_rsp", {b_rsp_z, b_rsp_r, b_rsp_div0}, 0);
        check("reset div_x", div_x, 0);
        check("reset div_y", div_y, 1);
        check("reset busy", busy, 0);

        // A alone: 7/3, response visible 7 cycles after the handshake.
        @(posedge clock); #1;
        issue_a({4'h7, 4'h3, 4'h2, 4'h1, 1'b0});
        n = 0;
        bseen = 1'b0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (b_rsp_valid) bseen = 1'b1;
            if (a_rsp_valid) break;
        end
        check("a_latency", n, 7);
        check("b_quiet", bseen, 0);
        wait_idle();

        // B: -7/2, then 6/0 (divider must see y=1).
        @(posedge clock); #1;
        issue_b({4'h9, 4'h2, 4'hD, 4'hF, 1'b0});
        check("div_y_normal", cap_y_b, 2);
        issue_b({4'h6, 4'h0, 4'hF, 4'h6, 1'b1});
        check("div_x_div0", cap_x_b, 6);
        check("div_y_div0", cap_y_b, 1);
        wait_idle();

        // Both requesters streaming: grants alternate starting with A.
        glog.delete();
        base_a = a_rcv;
        base_b = b_rcv;
        @(posedge clock); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) issue_a(va[i]);
            end
            begin
                for (int i = 0; i < 4; i++) issue_b(vb[i]);
            end
        join
        wait_idle();
        check("grant_count", glog.size(), 8);
        for (int i = 0; i < glog.size() && i < 8; i++) begin
            check($sformatf("grant_order[%0d]", i), glog[i], i % 2);
        end
        check("a_stream_rcv", a_rcv - base_a, 4);
        check("b_stream_rcv", b_rcv - base_b, 4);

        // A consumer stalled: A issues exactly DEPTH, B continues.
        @(posedge clock); #1;
        a_rsp_ready = 1'b0;
        base_ai = a_iss;
        base_bi = b_iss;
        a_cur = {4'h2, 4'h0, 1'b0};
        a_req_x = 4'h6;
        a_req_y = 4'h3;
        a_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) issue_b({4'h5, 4'h2, 4'h2, 4'h1, 1'b0});
        repeat (10) @(negedge clock);
        check("a_stall_issues", a_iss - base_ai, 4);
        check("a_stall_ready", a_req_ready, 0);
        check("b_stall_issues", b_iss - base_bi, 6);

        // One-cycle pop frees a credit on the following cycle.
        @(posedge clock); #1 a_rsp_ready = 1'b1;
        @(negedge clock);
        check("a_ready_during_pop", a_req_ready, 0);
        @(posedge clock); #1 a_rsp_ready = 1'b0;
        @(negedge clock);
        check("a_ready_after_pop", a_req_ready, 1);
        @(posedge clock); #1 a_req_valid = 1'b0;
        check("a_reissue", a_iss - base_ai, 5);

        // Retire and pop on the same edge: nothing lost or duplicated.
        repeat (5) @(posedge clock);
        base_a = a_rcv;
        #1 a_rsp_ready = 1'b1;
        @(negedge clock);
        check("a_valid_at_retire", a_rsp_valid, 1);
        @(posedge clock); #1 a_rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 a_rsp_ready = 1'b1;
        wait_idle();
        check("a_retire_pop_total", a_rcv - base_a, 4);

        // Reset with three operations in flight.
        @(posedge clock); #1;
        base_ai = a_iss + b_iss;
        a_cur = {4'h5, 4'h0, 1'b0};
        b_cur = {4'h3, 4'h0, 1'b0};
        a_req_x = 4'h5; a_req_y = 4'h1;
        b_req_x = 4'h3; b_req_y = 4'h1;
        a_req_valid = 1'b1;
        b_req_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        reset = 1'b1;
        check("inflight_before_reset", a_iss + b_iss - base_ai, 3);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("busy_after_reset", busy, 0);
        base_a = a_rcv;
        base_b = b_rcv;
        vseen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (a_rsp_valid || b_rsp_valid) vseen = 1'b1;
        end
        check("no_rsp_after_reset", vseen, 0);
        @(posedge clock); #1;
        issue_a({4'h5, 4'h2, 4'h2, 4'h1, 1'b0});
        wait_idle();
        check("a_rcv_after_reset", a_rcv - base_a, 1);
        check("b_rcv_after_reset", b_rcv - base_b, 0);
        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
